// File: rtl/hazard_tracker.sv
// hazard_tracker: load-use stall detection and forwarding-select generation for an in-order pipeline
module hazard_tracker #(
  parameter int RF_ADDRESS = 5,
  parameter int NSTAGES    = 3,
  parameter int NSRC       = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  parameter int FS_W       = $clog2(NSTAGES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [NSRC*RF_ADDRESS-1:0] id_rs,
  input  logic [NSRC-1:0]            id_rs_used,
  input  logic [RF_ADDRESS-1:0]      id_rd,
  input  logic                       id_regwrite,
  input  logic                       id_is_load,
  input  logic                       flush,
  input  logic                       ext_stall,
  output logic                       stall,
  output logic [NSRC*FS_W-1:0]       fwd_sel,
  output logic [NSTAGES-1:0]         valid_vec,
  output logic [CNT_W-1:0]           stall_cnt
);
  typedef struct packed {
    logic [RF_ADDRESS-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } entry_t;
  // The oldest entry only needs its valid bit: its rd/regwrite/is_load are never searched.
  logic [NSTAGES-1:0] r_valid;
  entry_t             r_ent [NSTAGES-1];
  logic [NSRC*FS_W-1:0] r_fwd;
  logic [CNT_W-1:0]   r_cnt;
  logic [NSRC*FS_W-1:0] w_sel;
  logic [NSRC-1:0]    w_haz;
  logic               w_stall;
  logic               w_bub;
  // Per source, scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    w_sel = '0;
    w_haz = '0;
    for (int i = 0; i < NSRC; i++)
      for (int k = NSTAGES-2; k >= 0; k--)
        if (id_valid && id_rs_used[i] && r_valid[k] && r_ent[k].regwrite &&
            r_ent[k].rd == id_rs[i*RF_ADDRESS +: RF_ADDRESS] && r_ent[k].rd != '0) begin
          w_sel[i*FS_W +: FS_W] = FS_W'(k+1);
          w_haz[i] = r_ent[k].is_load && (k+1 < LOAD_STAGE);
        end
  end
  assign w_stall   = ~reset & ~flush & ~ext_stall & |w_haz;
  assign w_bub     = w_stall | flush;
  assign stall     = w_stall;
  assign fwd_sel   = r_fwd;
  assign valid_vec = r_valid;
  assign stall_cnt = r_cnt;
  // Advance the tracked pipeline unless frozen; stalls and flushes inject a bubble into ID/EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_fwd   <= '0;
      r_cnt   <= '0;
      for (int j = 0; j < NSTAGES-1; j++) r_ent[j] <= '0;
    end else if (!ext_stall) begin
      r_valid <= {r_valid[NSTAGES-2:0], ~w_bub & id_valid};
      for (int j = NSTAGES-2; j > 0; j--) r_ent[j] <= r_ent[j-1];
      r_ent[0] <= w_bub ? '0 : {id_rd, id_regwrite, id_is_load};
      r_fwd    <= w_bub ? '0 : w_sel;
      if (w_stall && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule
